seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Display-side consumer for the push-button counter path: it takes the 8-bit counter value (0..255), converts it to three BCD digits with a sequential shift-add-3 converter, and time-multiplexes the digits onto a common-anode 3-digit 7-segment display. It sits between the up/down counter output and the board pins, driving the human-visible end of the chain that the button debouncer starts.

## Interface
Parameters:
- SCAN_W, default 13: scan prescaler width; the digit advances once every 2^SCAN_W clocks.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- value  input  8  unsigned binary value to display; sampled every clock.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}; registered.
- an  output  3  digit enables, active-low, an[0]=ones, an[1]=tens, an[2]=hundreds; registered.
- busy  output  1  high while a conversion is in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: when value != last_value, load value into the shift register, copy it to last_value, clear the 12-bit BCD work register, set bit_cnt=0, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd,bin} left by 1 and increment bit_cnt. After the 8th shift, go to COMMIT.
  - COMMIT: copy the work register to bcd_disp, then return to IDLE.
- value changes during SHIFT/COMMIT are not captured. On return to IDLE the mismatch is seen and a new conversion starts. Intermediate values may be skipped; the final value is always displayed.
- busy=1 in SHIFT and COMMIT, 0 in IDLE.
- Scan: a free-running SCAN_W-bit prescaler produces a tick when it equals 0. On each tick, digit_idx advances 0→1→2→0. The value 3 is never reached; if it occurs, the next clock forces it to 0.
- Leading-zero blanking:
  - The hundreds digit is blank when it is 0.
  - The tens digit is blank when both hundreds and tens are 0.
  - The ones digit is never blank.
  - Blank digits drive seg=7'b1111111, and their an bit is still asserted.
- Segment map (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble >9 is unreachable; if it occurs, drive blank.

## Timing
- Reset values: state=IDLE, last_value=0, bcd_disp=0, prescaler=0, digit_idx=0, busy=0, seg=7'b1111111, an=3'b111.
- seg/an are registered from (digit_idx, bcd_disp), giving one cycle of output latency. The first clock after reset release shows seg=1000000 with an=110.
- Conversion latency: value changes before edge t and is sampled in IDLE at edge t. SHIFT occupies edges t+1..t+8, COMMIT is at edge t+9, and bcd_disp is valid after edge t+9. The seg pins reflect it no later than the next scan of that digit plus 1 cycle.
- The display never shows a partially converted value, because bcd_disp changes only in COMMIT.
- Asynchronous reset mid-conversion aborts it. After release, value is compared against last_value=0, so a nonzero value triggers a fresh conversion.
- Digit period: 2^SCAN_W clocks per digit, a 3·2^SCAN_W frame. The prescaler wraps modulo 2^SCAN_W.

## Structure
- Shared package:
  - converter state enum {IDLE, SHIFT, COMMIT}
  - the ten segment constants and SEG_BLANK
  - digit-enable constants AN_ONES/AN_TENS/AN_HUND
- Sub-module bin2bcd_seq: holds the FSM, the shift/add-3 datapath, last_value compare, busy, and the 12-bit bcd output.
- seg_scan_display: holds the prescaler, digit_idx, blanking, segment decode, and output registers.

## Test plan
- Reset held low, then released with value=0 → seg=1000000, an=110 on the first clock. busy stays 0, and only an[0] ever enables non-blank.
- SCAN_W=3, value=8'd137 → busy high for exactly 9 cycles. Over the following frames: ones=7 (1111000, an=110), tens=3 (0110000, an=101), hundreds=1 (1111001, an=011).
- value=8'd5 after 137 → tens and hundreds slots show 1111111, and the ones slot shows 0010010.
- value=255, then value=18 injected 3 cycles into the conversion → 255 commits first, then a second conversion runs immediately. Final display: ones=8, tens=1, hundreds blank.
- Sweep value 0..255 with a conversion per value → bcd_disp matches the decimal reference for every value.
- reset asserted at SHIFT cycle 4 with value=200 → outputs go to reset values immediately. After release, 200 is converted and displayed 10 cycles later.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared types and constants for the 3-digit scanned 7-segment display path.
package seg_scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low digit enables.
  localparam logic [2:0] AN_ONES = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;
  localparam logic [2:0] AN_NONE = 3'b111;

  // BCD nibble to segment pattern; non-decimal nibbles go blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter with change detection.
module bin2bcd_seq
  import seg_scan_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd
);

  conv_state_t state, state_next;
  logic [7:0]  last_value;
  logic [7:0]  bin;
  logic [11:0] work;
  logic [11:0] adj;
  logic [19:0] shifted;
  logic [2:0]  bit_cnt;
  logic [11:0] bcd_disp;

  // Converter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:   if (value != last_value) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (bit_cnt == 3'd7) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add 3 to every nibble >= 5, then shift {bcd,bin} left one place.
  always_comb begin
    adj = work;
    for (int unsigned i = 0; i < 3; i++) begin
      if (work[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
    end
    shifted = {adj, bin} << 1;
  end

  // Conversion datapath; bcd_disp only moves in COMMIT so the display never sees partial results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_value <= '0;
      bin        <= '0;
      work       <= '0;
      bit_cnt    <= '0;
      bcd_disp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            bin        <= value;
            last_value <= value;
            work       <= '0;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          work    <= shifted[19:8];
          bin     <= shifted[7:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        COMMIT: bcd_disp <= work;
        default: ;
      endcase
    end
  end

  assign bcd = bcd_disp;

endmodule

// File: rtl/seg_scan_display.sv
// Top: BCD conversion of an 8-bit value, time-multiplexed onto a 3-digit common-anode display.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int SCAN_W = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  logic [11:0]       bcd_disp;
  logic [SCAN_W-1:0] prescaler;
  logic              tick;
  logic [1:0]        digit_idx;
  logic [6:0]        seg_next;
  logic [2:0]        an_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .busy  (busy),
    .bcd   (bcd_disp)
  );

  assign tick = (prescaler == '0);

  // Free-running prescaler and digit scan index; index 3 is illegal and recovers to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (digit_idx == 2'd3)    digit_idx <= '0;
      else if (tick)            digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end
  end

  // Digit select with leading-zero blanking.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = AN_NONE;
    case (digit_idx)
      2'd0: begin
        an_next  = AN_ONES;
        seg_next = seg_decode(bcd_disp[3:0]);
      end
      2'd1: begin
        an_next  = AN_TENS;
        seg_next = (bcd_disp[11:4] == '0) ? SEG_BLANK : seg_decode(bcd_disp[7:4]);
      end
      2'd2: begin
        an_next  = AN_HUND;
        seg_next = (bcd_disp[11:8] == '0) ? SEG_BLANK : seg_decode(bcd_disp[11:8]);
      end
      default: ;
    endcase
  end

  // Registered pin drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      an  <= AN_NONE;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized and directed bench for seg_scan_display against a decimal-arithmetic reference.
module tb_seg_scan_display;

  localparam int SCAN_W = 3;
  localparam int DIGIT_CYC = 1 << SCAN_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  seg_scan_display #(.SCAN_W(SCAN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model state: the display as a number, plus a conversion countdown.
  int         m_last, m_cap, m_disp, m_left, m_pre, m_digit;
  logic [6:0] m_seg;
  logic [2:0] m_an;
  bit         m_committed;

  function automatic logic [9:0] ref_out(input int digit, input int v);
    int d;
    bit blank;
    logic [2:0] a;
    case (digit)
      0:       begin d = v % 10;        blank = 1'b0;     a = 3'b110; end
      1:       begin d = (v / 10) % 10; blank = (v < 10);  a = 3'b101; end
      default: begin d = v / 100;       blank = (v < 100); a = 3'b011; end
    endcase
    return {a, blank ? 7'b1111111 : seg_tab[d]};
  endfunction

  task automatic model_reset();
    m_last = 0; m_cap = 0; m_disp = 0; m_left = 0; m_pre = 0; m_digit = 0;
    m_seg = 7'b1111111; m_an = 3'b111; m_committed = 1'b0;
  endtask

  task automatic model_edge();
    m_committed = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      {m_an, m_seg} = ref_out(m_digit, m_disp);
      if (m_left == 0) begin
        if (int'(value) != m_last) begin
          m_last = value; m_cap = value; m_left = 9;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_cap;
          m_committed = 1'b1;
        end
      end
      if (m_pre == 0) m_digit = (m_digit + 1) % 3;
      m_pre = (m_pre + 1) % DIGIT_CYC;
    end
  endtask

  // One clock: advance model at the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("seg", seg, m_seg);
    check_eq("an", an, m_an);
    check_eq("busy", busy, (m_left != 0));
    if (m_committed)
      check_eq("bcd_disp", dut.bcd_disp,
               {4'(m_disp / 100), 4'((m_disp / 10) % 10), 4'(m_disp % 10)});
  endtask

  // Run n clocks and compare each lit digit against fixed patterns.
  task automatic frame_check(input string tag, input logic [6:0] s1, input logic [6:0] s10,
                             input logic [6:0] s100, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (an == 3'b110) check_eq({tag, "_ones"}, seg, s1);
      else if (an == 3'b101) check_eq({tag, "_tens"}, seg, s10);
      else if (an == 3'b011) check_eq({tag, "_hund"}, seg, s100);
      else check_eq({tag, "_an"}, an, 3'b110);
    end
  endtask

  int busy_cnt;

  initial begin
    model_reset();
    // Reset held, then released with value 0.
    repeat (3) tick();
    check_eq("rst_seg", seg, 7'b1111111);
    check_eq("rst_an", an, 3'b111);
    reset = 1'b1;
    tick();
    check_eq("first_seg", seg, 7'b1000000);
    check_eq("first_an", an, 3'b110);
    frame_check("zero", 7'b1000000, 7'b1111111, 7'b1111111, 3 * DIGIT_CYC * 2);

    // 137: busy length then steady display.
    value = 8'd137;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    check_eq("busy_len", busy_cnt, 9);
    frame_check("v137", 7'b1111000, 7'b0110000, 7'b1111001, 3 * DIGIT_CYC * 2);

    // 5: leading-zero blanking of tens and hundreds.
    value = 8'd5;
    repeat (12) tick();
    frame_check("v5", 7'b0010010, 7'b1111111, 7'b1111111, 3 * DIGIT_CYC * 2);

    // 255 then 18 injected mid-conversion.
    value = 8'd255;
    repeat (3) tick();
    value = 8'd18;
    repeat (6) tick();
    check_eq("v255_pending", dut.bcd_disp, 12'h000 | 12'h005);
    repeat (24) tick();
    frame_check("v18", 7'b0000000, 7'b1111001, 7'b1111111, 3 * DIGIT_CYC * 2);

    // Full sweep, one conversion per value.
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      repeat (11) tick();
    end

    // Random values with random hold times.
    for (int i = 0; i < 300; i++) begin
      value = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 15)) tick();
    end

    // Reset in SHIFT cycle 4 with value 200.
    value = 8'd0;
    repeat (12) tick();
    value = 8'd200;
    repeat (5) tick();
    check_eq("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_seg", seg, 7'b1111111);
    check_eq("async_an", an, 3'b111);
    check_eq("async_busy", busy, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check_eq("v200_bcd", dut.bcd_disp, 12'h200);
    frame_check("v200", 7'b1000000, 7'b1000000, 7'b0100100, 3 * DIGIT_CYC * 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
